// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: alignment check, store lane formatting, load extraction.
// Define LSU_STORE_TIMEOUT_EN to fault stores that see no completion within TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  reqValid_i,
    output logic                  reqReady_o,
    input  logic                  reqIsStore_i,
    input  logic [2:0]            reqFunct3_i,
    input  logic [ADDR_WIDTH-1:0] reqAddress_i,
    input  logic [31:0]           reqStoreData_i,
    output logic                  respValid_o,
    output logic [31:0]           respData_o,
    output logic                  respMisaligned_o,
    output logic                  respTimeout_o,
    output logic [ADDR_WIDTH-1:0] memAddress_o,
    output logic [31:0]           memStoreData_o,
    output logic [3:0]            memByteEnable_o,
    output logic                  memStoreValid_o,
    input  logic [31:0]           memLoadData_i,
    input  logic                  memLoadDataValid_i,
    input  logic                  memStoreComplete_i
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, STORE_GAP} state_t;

    state_t                  state_q;
    logic                    reqReady_q;
    logic                    respValid_q;
    logic [31:0]             respData_q;
    logic                    respMisaligned_q;
    logic                    respTimeout_q;
    logic [ADDR_WIDTH-1:0]   memAddress_q;
    logic [31:0]             memStoreData_q;
    logic [3:0]              memByteEnable_q;
    logic                    memStoreValid_q;
    logic [1:0]              lane_q;
    logic [2:0]              funct3_q;

    logic                    req_fault_d;
    logic [3:0]              store_be_d;
    logic [31:0]             store_data_d;
    logic [31:0]             load_data_d;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic                    timeout_hit;

    // Request decode: illegal funct3 for the direction, then natural alignment of the access size.
    always_comb begin
        req_fault_d = 1'b0;
        if (reqIsStore_i) begin
            if (reqFunct3_i[2] || (reqFunct3_i[1:0] == 2'd3)) begin
                req_fault_d = 1'b1;
            end
        end else begin
            if ((reqFunct3_i == 3'd3) || (reqFunct3_i[2:1] == 2'b11)) begin
                req_fault_d = 1'b1;
            end
        end
        case (reqFunct3_i[1:0])
            2'd1: begin
                if (reqAddress_i[0]) begin
                    req_fault_d = 1'b1;
                end
            end
            2'd2: begin
                if (reqAddress_i[1:0] != 2'b00) begin
                    req_fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        store_data_d = reqStoreData_i;
        store_be_d   = 4'b1111;
        case (reqFunct3_i[1:0])
            2'd0: begin
                store_data_d = {4{reqStoreData_i[7:0]}};
                store_be_d   = 4'b0001 << reqAddress_i[1:0];
            end
            2'd1: begin
                store_data_d = {2{reqStoreData_i[15:0]}};
                store_be_d   = reqAddress_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    load_byte = memLoadData_i[7:0];
            2'd1:    load_byte = memLoadData_i[15:8];
            2'd2:    load_byte = memLoadData_i[23:16];
            default: load_byte = memLoadData_i[31:24];
        endcase
        load_half = lane_q[1] ? memLoadData_i[31:16] : memLoadData_i[15:0];
        case (funct3_q)
            3'd0:    load_data_d = {{24{load_byte[7]}}, load_byte};
            3'd4:    load_data_d = {24'd0, load_byte};
            3'd1:    load_data_d = {{16{load_half[15]}}, load_half};
            3'd5:    load_data_d = {16'd0, load_half};
            default: load_data_d = memLoadData_i;
        endcase
    end

`ifdef LSU_STORE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counts cycles already spent in STORE; zero on the first STORE cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == STORE) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == STORE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            reqReady_q       <= 1'b1;
            respValid_q      <= 1'b0;
            respData_q       <= '0;
            respMisaligned_q <= 1'b0;
            respTimeout_q    <= 1'b0;
            memAddress_q     <= '0;
            memStoreData_q   <= '0;
            memByteEnable_q  <= '0;
            memStoreValid_q  <= 1'b0;
            lane_q           <= '0;
            funct3_q         <= '0;
        end else begin
            // Response fields are single-cycle pulses unless set below.
            respValid_q      <= 1'b0;
            respData_q       <= '0;
            respMisaligned_q <= 1'b0;
            respTimeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqValid_i) begin
                        if (req_fault_d) begin
                            respValid_q      <= 1'b1;
                            respMisaligned_q <= 1'b1;
                        end else begin
                            memAddress_q <= {reqAddress_i[ADDR_WIDTH-1:2], 2'b00};
                            lane_q       <= reqAddress_i[1:0];
                            funct3_q     <= reqFunct3_i;
                            reqReady_q   <= 1'b0;
                            if (reqIsStore_i) begin
                                state_q         <= STORE;
                                memStoreData_q  <= store_data_d;
                                memByteEnable_q <= store_be_d;
                                memStoreValid_q <= 1'b1;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (memLoadDataValid_i) begin
                        state_q     <= IDLE;
                        reqReady_q  <= 1'b1;
                        respValid_q <= 1'b1;
                        respData_q  <= load_data_d;
                    end
                end
                STORE: begin
                    // Completion takes priority over a coincident timeout.
                    if (memStoreComplete_i || timeout_hit) begin
                        state_q         <= STORE_GAP;
                        memStoreValid_q <= 1'b0;
                        memByteEnable_q <= '0;
                        respValid_q     <= 1'b1;
                        respTimeout_q   <= !memStoreComplete_i;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign reqReady_o       = reqReady_q;
    assign respValid_o      = respValid_q;
    assign respData_o       = respData_q;
    assign respMisaligned_o = respMisaligned_q;
    assign respTimeout_o    = respTimeout_q;
    assign memAddress_o     = memAddress_q;
    assign memStoreData_o   = memStoreData_q;
    assign memByteEnable_o  = memByteEnable_q;
    assign memStoreValid_o  = memStoreValid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
// Define LSU_STORE_TIMEOUT_EN here as well as in the RTL to exercise the store timeout.
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_sdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_mis;
    logic        resp_tmo;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [3:0]  mem_be;
    logic        mem_sv;
    logic [31:0] mem_ldata;
    logic        mem_ld_valid;
    logic        mem_st_cmpl;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(32)) dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .reqValid_i         (req_valid),
        .reqReady_o         (req_ready),
        .reqIsStore_i       (req_is_store),
        .reqFunct3_i        (req_funct3),
        .reqAddress_i       (req_addr),
        .reqStoreData_i     (req_sdata),
        .respValid_o        (resp_valid),
        .respData_o         (resp_data),
        .respMisaligned_o   (resp_mis),
        .respTimeout_o      (resp_tmo),
        .memAddress_o       (mem_addr),
        .memStoreData_o     (mem_sdata),
        .memByteEnable_o    (mem_be),
        .memStoreValid_o    (mem_sv),
        .memLoadData_i      (mem_ldata),
        .memLoadDataValid_i (mem_ld_valid),
        .memStoreComplete_i (mem_st_cmpl)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size from funct3, natural alignment, legal funct3 sets.
    function automatic bit exp_fault(input bit is_store, input int f3, input logic [31:0] addr);
        int size_log2 = f3 % 4;
        if (is_store && f3 >= 3) return 1'b1;
        if (!is_store && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (size_log2 == 1 && (addr % 2) != 0) return 1'b1;
        if (size_log2 == 2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
        int unsigned lane = addr % 4;
        logic [31:0] b = (word >> (8 * lane)) & 32'hFF;
        logic [31:0] h = (word >> (16 * (lane / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 32'd128)   ? b - 32'd256   : b;
            1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            4:       return b;
            5:       return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] exp_be(input int f3, input logic [31:0] addr);
        int unsigned lane = addr % 4;
        if (f3 == 0) return 32'd1 << lane;
        if (f3 == 1) return (lane >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_sdata(input int f3, input logic [31:0] data);
        if (f3 == 0) return (data & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (data & 32'hFFFF) * 32'h00010001;
        return data;
    endfunction

    // One request from issue to the idle cycle after its response; delay = memory wait cycles.
    task automatic do_txn(input bit is_store, input int f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] ldword, input int delay);
        bit fault = exp_fault(is_store, f3, addr);
        bit exp_to = 1'b0;
        int n_wait = delay;
        txn_no++;
        $display("txn %0d: %s f3=%0d addr=%h sdata=%h ldword=%h delay=%0d fault=%0d",
                 txn_no, is_store ? "store" : "load", f3, addr, sdata, ldword, delay, fault);
        check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = is_store;
        req_funct3   = 3'(f3);
        req_addr     = addr;
        req_sdata    = sdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_sdata = $urandom;
        if (fault) begin
            check_eq("fault_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("fault_misaligned", {31'd0, resp_mis}, 32'd1);
            check_eq("fault_resp_data", resp_data, 32'd0);
            check_eq("fault_store_valid", {31'd0, mem_sv}, 32'd0);
            check_eq("fault_ready", {31'd0, req_ready}, 32'd1);
        end else if (!is_store) begin
            check_eq("load_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check_eq("load_store_valid", {31'd0, mem_sv}, 32'd0);
            check_eq("load_byte_en", {28'd0, mem_be}, 32'd0);
            check_eq("load_ready_busy", {31'd0, req_ready}, 32'd0);
            for (int i = 0; i < delay; i++) begin
                check_eq("load_wait_no_resp", {31'd0, resp_valid}, 32'd0);
                @(posedge clk); #1;
            end
            mem_ld_valid = 1'b1;
            mem_ldata    = ldword;
            @(posedge clk); #1;
            mem_ld_valid = 1'b0;
            mem_ldata    = $urandom;
            check_eq("load_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("load_resp_data", resp_data, exp_load(f3, addr, ldword));
            check_eq("load_misaligned", {31'd0, resp_mis}, 32'd0);
            check_eq("load_ready_resp", {31'd0, req_ready}, 32'd1);
        end else begin
`ifdef LSU_STORE_TIMEOUT_EN
            if (delay >= TMO) begin
                n_wait = TMO - 1;
                exp_to = 1'b1;
            end
`endif
            check_eq("store_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check_eq("store_byte_en", {28'd0, mem_be}, exp_be(f3, addr));
            check_eq("store_data", mem_sdata, exp_sdata(f3, sdata));
            check_eq("store_ready_busy", {31'd0, req_ready}, 32'd0);
            for (int i = 0; i < n_wait; i++) begin
                check_eq("store_valid_held", {31'd0, mem_sv}, 32'd1);
                @(posedge clk); #1;
            end
            check_eq("store_valid_last", {31'd0, mem_sv}, 32'd1);
            mem_st_cmpl = !exp_to;
            @(posedge clk); #1;
            mem_st_cmpl = 1'b0;
            check_eq("gap_store_valid", {31'd0, mem_sv}, 32'd0);
            check_eq("gap_byte_en", {28'd0, mem_be}, 32'd0);
            check_eq("gap_ready", {31'd0, req_ready}, 32'd0);
            check_eq("store_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("store_resp_data", resp_data, 32'd0);
            check_eq("store_misaligned", {31'd0, resp_mis}, 32'd0);
            check_eq("store_timeout", {31'd0, resp_tmo}, {31'd0, exp_to});
        end
        // A stray completion pulse while idle must be ignored.
        mem_st_cmpl = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        mem_st_cmpl = 1'b0;
        check_eq("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
        check_eq("idle_store_valid", {31'd0, mem_sv}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 32'd0;
        req_sdata    = 32'd0;
        mem_ldata    = 32'd0;
        mem_ld_valid = 1'b0;
        mem_st_cmpl  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_misaligned", {31'd0, resp_mis}, 32'd0);
        check_eq("rst_timeout", {31'd0, resp_tmo}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_sdata", mem_sdata, 32'd0);
        check_eq("rst_byte_en", {28'd0, mem_be}, 32'd0);
        check_eq("rst_store_valid", {31'd0, mem_sv}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b1, 2, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1);
        do_txn(1'b1, 0, 32'h0000_0203, 32'h0000_00A5, 32'd0, 0);
        do_txn(1'b1, 1, 32'h0000_0206, 32'h1234_5678, 32'd0, 2);
        do_txn(1'b0, 0, 32'h0000_0301, 32'd0, 32'h0000_8000, 0);
        do_txn(1'b0, 4, 32'h0000_0301, 32'd0, 32'h0000_8000, 1);
        do_txn(1'b0, 5, 32'h0000_0302, 32'd0, 32'hBEEF_0000, 3);
        do_txn(1'b0, 1, 32'h0000_0302, 32'd0, 32'hBEEF_0000, 0);
        do_txn(1'b0, 2, 32'h0000_0104, 32'd0, 32'hCAFE_F00D, 2);
        do_txn(1'b0, 2, 32'h0000_0102, 32'd0, 32'd0, 0);
        do_txn(1'b1, 1, 32'h0000_0001, 32'd0, 32'd0, 0);
        do_txn(1'b1, 3, 32'h0000_0000, 32'd0, 32'd0, 0);
        do_txn(1'b0, 6, 32'h0000_0000, 32'd0, 32'd0, 0);

        // Asynchronous reset in the middle of a store.
        $display("txn reset-mid-store: SW addr=00000400");
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'd2;
        req_addr     = 32'h0000_0400;
        req_sdata    = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("pre_rst_store_valid", {31'd0, mem_sv}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_store_valid", {31'd0, mem_sv}, 32'd0);
        check_eq("async_rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("async_rst_byte_en", {28'd0, mem_be}, 32'd0);
        #2 rst = 1'b0;
        mem_st_cmpl = 1'b1;
        @(posedge clk); #1;
        mem_st_cmpl = 1'b0;
        check_eq("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

`ifdef LSU_STORE_TIMEOUT_EN
        do_txn(1'b1, 2, 32'h0000_0500, 32'h1111_2222, 32'd0, TMO + 4);
        do_txn(1'b1, 2, 32'h0000_0504, 32'h3333_4444, 32'd0, TMO - 1);
`endif

        for (int n = 0; n < 150; n++) begin
            bit          st = $urandom_range(0, 1);
            int          f3 = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2))
                              + ((!st && $urandom_range(0, 1) == 1) ? 4 : 0);
            logic [31:0] a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (f3 % 4 == 2) ? 2'd0 : {($urandom_range(0, 1) == 1), 1'b0};
            do_txn(st, f3 % 8, a, $urandom, $urandom, $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
